aemb_ifetch_fifo: RTL and testbench
===================================

# aemb_ifetch_fifo

Instruction prefetch stage that sits directly upstream of the AEMB instruction buffer. It generates sequential word addresses on the instruction Wishbone bus and queues returned words in a small FIFO. It presents the head word to the instruction buffer, which advances it with `gena`. A taken branch flushes the queue and redirects fetch to the branch target.

## Interface
Parameters:
- `DEPTH_LOG2`, 2: FIFO depth is 2^DEPTH_LOG2 entries.
- `AW`, 30: word-address width; the byte address is {iwb_adr_o, 2'b00}.
- `RESET_PC`, 0: word address fetched first after reset.

Ports:
- `gclk` in 1: clock; the block uses this single clock.
- `grst` in 1: reset, asynchronous, active-high.
- `iwb_adr_o` out AW: fetch word address.
- `iwb_stb_o` out 1: Wishbone strobe (classic cycle).
- `iwb_dat_i` in 32: returned instruction word.
- `iwb_ack_i` in 1: Wishbone acknowledge.
- `rBRA` in 1: branch taken; flush and redirect.
- `rBRATGT` in AW: branch target word address, qualified by `rBRA`.
- `gena` in 1: consumer advance; pops the head word when `ifq_vld_o` is high.
- `ifq_dat_o` out 32: head instruction; 32'h88000000 when empty.
- `ifq_pc_o` out AW: word address of the head instruction; 0 when empty.
- `ifq_vld_o` out 1: FIFO non-empty.

## Operation
- Storage is a DEPTH-entry array of {pc, word}, with wrap-around read and write pointers (DEPTH_LOG2 bits) and a count (DEPTH_LOG2+1 bits).
- Fetch counter `rPC` (AW bits) increments by 1 per accepted ack. It wraps modulo 2^AW.
- `iwb_adr_o` = `rPC` at all times. `iwb_stb_o` is high only in state FETCH.
- A push occurs on `iwb_stb_o & iwb_ack_i & ~rBRA`. It writes {rPC, iwb_dat_i} at the write pointer. Acks while strobe is low are ignored.
- A pop occurs on `gena & ifq_vld_o & ~rBRA`.
- Simultaneous push and pop leaves count unchanged. Push is impossible at count == DEPTH because the strobe is low.
- Flush occurs on `rBRA` at a clock edge:
  - pointers and count go to 0;
  - `rPC` <= `rBRATGT`;
  - any coincident ack or pop is discarded.
  - `rBRA` has priority over every other event.
- FSM, reset state IDLE:
  - IDLE: strobe 0. On `rBRA` go to FLUSH. Else, if count_next < DEPTH, go to FETCH.
  - FETCH: strobe 1. On `rBRA` go to FLUSH. Else, if a push makes count_next == DEPTH, go to IDLE. Otherwise stay.
  - FLUSH: strobe 0 for exactly one cycle; this aborts any pending bus cycle. On `rBRA` reload `rPC` and stay in FLUSH. Otherwise go to FETCH.
- count_next includes the same-cycle push and pop.

## Timing
- Reset values: `iwb_stb_o`=0, `iwb_adr_o`=RESET_PC, `ifq_vld_o`=0, `ifq_dat_o`=32'h88000000, `ifq_pc_o`=0.
- Reset acts immediately when `grst` rises, including in the middle of a bus cycle or with data in the queue.
- First strobe appears in the cycle after the first `gclk` edge with `grst` low.
- Ack-to-visible latency is 1 cycle: the word accepted at edge N is on `ifq_dat_o` with `ifq_vld_o`=1 after edge N.
- Sustained throughput is 1 word/cycle with ack every cycle and `gena` high.
- Branch at edge N gives:
  - strobe low and `ifq_vld_o`=0 after edge N;
  - strobe high with `iwb_adr_o`=target after edge N+1;
  - first target word visible after the ack edge plus 1.
- Full: strobe drops after the edge that fills the FIFO. It re-rises the cycle after a pop edge.

## Configuration
- `AEMB_IFETCH_BYPASS_EN` defined:
  - When count == 0 and an ack without `rBRA` is present, `ifq_dat_o`=`iwb_dat_i`, `ifq_pc_o`=`rPC` and `ifq_vld_o`=1 combinationally in the same cycle.
  - If `gena` is also high, the word is consumed and not written; count stays 0.
  - Ack-to-visible latency is 0 when the FIFO is empty.
- Not defined: outputs come only from registered storage, with latency always 1. There is no combinational path from `iwb_dat_i`/`iwb_ack_i` to the `ifq_*` outputs.

## Test plan
- Reset release with ack every cycle and `gena`=1, RESET_PC=0, memory word = 32'hA0000000+addr:
  - `iwb_adr_o` steps 0,1,2,…;
  - `ifq_dat_o` shows A0000000, A0000001,… one cycle behind the ack.
- `gena`=0 with DEPTH_LOG2=2:
  - after 4 acks, strobe goes low, count is 4 and `ifq_vld_o`=1;
  - a single `gena` pulse pops one word, and strobe returns high the next cycle with `iwb_adr_o`=4.
- `rBRA`=1 with `rBRATGT`=0x100 in the same cycle as ack and `gena`:
  - the ack word is dropped and `ifq_vld_o`=0;
  - strobe is low one cycle, then `iwb_adr_o`=0x100;
  - the next visible `ifq_pc_o` is 0x100.
- Back-to-back `rBRA` with targets 0x10 then 0x20 on consecutive edges: the FSM stays in FLUSH, then fetches 0x20; 0x10 is never strobed.
- RESET_PC=2^AW−1 with acks: `iwb_adr_o` wraps to 0 and `ifq_pc_o` follows 3FFFFFFF, 0.
- `grst` raised mid-cycle with 3 entries queued and strobe high: all outputs take reset values before the next edge. With `AEMB_IFETCH_BYPASS_EN`, on an empty FIFO, an ack of 32'h12345678 with `gena`=1 appears on `ifq_dat_o` in the same cycle and count stays 0.

Source files
------------

// File: rtl/aemb_ifetch_fifo.sv
// aemb_ifetch_fifo: instruction prefetch queue in front of the AEMB
// instruction buffer. Issues sequential word fetches on a classic-cycle
// Wishbone bus, queues {pc, word} pairs, and flushes/redirects on a taken
// branch.
//
// Optional feature: define AEMB_IFETCH_BYPASS_EN to forward an ack straight
// to the ifq_* outputs when the queue is empty (zero-latency bypass).
//
// Consumer handshake: ifq_vld_o is the valid, gena is the ready. A word is
// transferred on a clock edge where both are high and rBRA is low; the
// consumer may hold gena high while ifq_vld_o is low without effect.
module aemb_ifetch_fifo #(
    parameter int              DEPTH_LOG2 = 2,
    parameter int              AW         = 30,
    parameter logic [AW-1:0]   RESET_PC   = '0
) (
    input  logic            gclk,
    input  logic            grst,
    output logic [AW-1:0]   iwb_adr_o,
    output logic            iwb_stb_o,
    input  logic [31:0]     iwb_dat_i,
    input  logic            iwb_ack_i,
    input  logic            rBRA,
    input  logic [AW-1:0]   rBRATGT,
    input  logic            gena,
    output logic [31:0]     ifq_dat_o,
    output logic [AW-1:0]   ifq_pc_o,
    output logic            ifq_vld_o
);

    localparam int                  DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [31:0]         C_NOP  = 32'h88000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_pc;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [31:0]           r_mem_dat [DEPTH];
    logic [AW-1:0]         r_mem_pc  [DEPTH];

    logic                  w_stb;
    logic                  w_push;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_nonempty;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // Strobe is a pure decode of the registered state, so it never glitches.
    assign w_stb      = (r_state == ST_FETCH);
    assign w_push     = w_stb & iwb_ack_i & ~rBRA;
    assign w_nonempty = (r_count != '0);
    assign w_rd       = gena & w_nonempty & ~rBRA;

`ifdef AEMB_IFETCH_BYPASS_EN
    logic w_byp;
    // An accepted word arriving at an empty queue is shown immediately; if
    // the consumer takes it in the same cycle it never enters storage.
    assign w_byp = w_push & ~w_nonempty;
    assign w_wr  = w_push & ~(w_byp & gena);
`else
    assign w_wr  = w_push;
`endif

    assign iwb_adr_o = r_pc;
    assign iwb_stb_o = w_stb;

    // Occupancy after this edge, folding in same-cycle write and read.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(1);
        end else if (!w_wr && w_rd) begin
            w_count_nxt = r_count - (DEPTH_LOG2 + 1)'(1);
        end
    end

    // Head-of-queue presentation; a NOP pattern is shown when nothing is valid.
    always_comb begin
        ifq_vld_o = w_nonempty;
        ifq_dat_o = w_nonempty ? r_mem_dat[r_rptr] : C_NOP;
        ifq_pc_o  = w_nonempty ? r_mem_pc[r_rptr]  : '0;
`ifdef AEMB_IFETCH_BYPASS_EN
        if (w_byp) begin
            ifq_vld_o = 1'b1;
            ifq_dat_o = iwb_dat_i;
            ifq_pc_o  = r_pc;
        end
`endif
    end

    // Queue storage; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge gclk) begin
        if (w_wr) begin
            r_mem_dat[r_wptr] <= iwb_dat_i;
            r_mem_pc[r_wptr]  <= r_pc;
        end
    end

    // Pointers, occupancy and fetch counter; a branch overrides everything.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (rBRA) begin
            r_pc    <= rBRATGT;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_pc <= r_pc + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Fetch sequencer: fetch while there is room, one dead cycle after a
    // branch so any outstanding bus cycle is abandoned.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_state <= ST_IDLE;
        end else if (rBRA) begin
            r_state <= ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_count_nxt < C_FULL) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_wr && (w_count_nxt == C_FULL)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aemb_ifetch_fifo.sv
// Directed bench for aemb_ifetch_fifo: a per-cycle vector table covering
// streaming, fill-to-full, branch flush and back-to-back branches, plus
// hand-written sequences for address wrap, asynchronous reset and the
// ack-to-visible latency (with or without the bypass build).
module tb_aemb_ifetch_fifo;

    localparam int          AW    = 30;
    localparam logic [31:0] NOP   = 32'h88000000;

    // ---------------- clock / reset ----------------
    logic gclk = 1'b0;
    logic grst = 1'b1;
    always #5 gclk = ~gclk;

    // ---------------- DUT 0: RESET_PC = 0 ----------------
    logic [AW-1:0] adr0;
    logic          stb0;
    logic [31:0]   dat0;
    logic          ack0;
    logic          bra0;
    logic [AW-1:0] tgt0;
    logic          gena0;
    logic [31:0]   qdat0;
    logic [AW-1:0] qpc0;
    logic          qvld0;

    aemb_ifetch_fifo #(.DEPTH_LOG2(2), .AW(AW), .RESET_PC('0)) dut0 (
        .gclk(gclk), .grst(grst),
        .iwb_adr_o(adr0), .iwb_stb_o(stb0), .iwb_dat_i(dat0), .iwb_ack_i(ack0),
        .rBRA(bra0), .rBRATGT(tgt0), .gena(gena0),
        .ifq_dat_o(qdat0), .ifq_pc_o(qpc0), .ifq_vld_o(qvld0)
    );

    // ---------------- DUT 1: RESET_PC = all ones, ack on every strobe ----
    logic [AW-1:0] adr1;
    logic          stb1;
    logic [31:0]   dat1;
    logic          ack1;
    logic [31:0]   qdat1;
    logic [AW-1:0] qpc1;
    logic          qvld1;

    assign ack1 = stb1;
    assign dat1 = {2'b00, adr1};

    aemb_ifetch_fifo #(.DEPTH_LOG2(2), .AW(AW), .RESET_PC({AW{1'b1}})) dut1 (
        .gclk(gclk), .grst(grst),
        .iwb_adr_o(adr1), .iwb_stb_o(stb1), .iwb_dat_i(dat1), .iwb_ack_i(ack1),
        .rBRA(1'b0), .rBRATGT({AW{1'b0}}), .gena(1'b1),
        .ifq_dat_o(qdat1), .ifq_pc_o(qpc1), .ifq_vld_o(qvld1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stb"}, 32'(stb0), 32'd0);
        chk({tag, "_adr"}, 32'(adr0), 32'd0);
        chk({tag, "_vld"}, 32'(qvld0), 32'd0);
        chk({tag, "_dat"}, qdat0, NOP);
        chk({tag, "_pc"},  32'(qpc0), 32'd0);
        chk({tag, "_adr1"}, 32'(adr1), 32'h3FFFFFFF);
    endtask

    // Watch for the abandoned first branch target ever being strobed.
    logic saw_10 = 1'b0;
    always @(negedge gclk) begin
        if (stb0 && adr0 == 30'h10) saw_10 = 1'b1;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          bra;
        logic [AW-1:0] tgt;
        logic          ack;
        logic [31:0]   dat;
        logic          gena;
        logic          e_stb;
        logic [AW-1:0] e_adr;
        logic          e_vld;
        logic [31:0]   e_dat;
        logic [AW-1:0] e_pc;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic bra, input logic [AW-1:0] tgt,
                                input logic ack, input logic [31:0] dat,
                                input logic gena, input logic e_stb,
                                input logic [AW-1:0] e_adr, input logic e_vld,
                                input logic [31:0] e_dat, input logic [AW-1:0] e_pc);
        vec_t v;
        v.bra = bra; v.tgt = tgt; v.ack = ack; v.dat = dat; v.gena = gena;
        v.e_stb = e_stb; v.e_adr = e_adr; v.e_vld = e_vld; v.e_dat = e_dat; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive(input logic bra, input logic [AW-1:0] tgt, input logic ack,
                         input logic [31:0] dat, input logic gena);
        bra0 = bra; tgt0 = tgt; ack0 = ack; dat0 = dat; gena0 = gena;
    endtask

    initial begin
        // Inputs: this cycle's stimulus. Expected: outputs seen before the edge.
        //            bra tgt    ack dat           gena | stb adr    vld dat           pc
        vecs[0]  = mk(0, 'h0,   0, 32'h0,        1,     0, 'h0,   0, NOP,          'h0);
        vecs[1]  = mk(0, 'h0,   1, 32'hA0000000, 1,     1, 'h0,   0, NOP,          'h0);
        vecs[2]  = mk(0, 'h0,   1, 32'hA0000001, 1,     1, 'h1,   1, 32'hA0000000, 'h0);
        vecs[3]  = mk(0, 'h0,   1, 32'hA0000002, 0,     1, 'h2,   1, 32'hA0000001, 'h1);
        vecs[4]  = mk(0, 'h0,   1, 32'hA0000003, 0,     1, 'h3,   1, 32'hA0000001, 'h1);
        vecs[5]  = mk(0, 'h0,   1, 32'hA0000004, 0,     1, 'h4,   1, 32'hA0000001, 'h1);
        vecs[6]  = mk(0, 'h0,   1, 32'hDEADBEEF, 0,     0, 'h5,   1, 32'hA0000001, 'h1);
        vecs[7]  = mk(0, 'h0,   0, 32'h0,        1,     0, 'h5,   1, 32'hA0000001, 'h1);
        vecs[8]  = mk(0, 'h0,   0, 32'h0,        0,     1, 'h5,   1, 32'hA0000002, 'h2);
        vecs[9]  = mk(1, 'h100, 1, 32'hA0000005, 1,     1, 'h5,   1, 32'hA0000002, 'h2);
        vecs[10] = mk(0, 'h0,   1, 32'hA0000100, 1,     0, 'h100, 0, NOP,          'h0);
        vecs[11] = mk(0, 'h0,   1, 32'hA0000100, 0,     1, 'h100, 0, NOP,          'h0);
        vecs[12] = mk(1, 'h10,  0, 32'h0,        0,     1, 'h101, 1, 32'hA0000100, 'h100);
        vecs[13] = mk(1, 'h20,  0, 32'h0,        0,     0, 'h10,  0, NOP,          'h0);
        vecs[14] = mk(0, 'h0,   0, 32'h0,        0,     0, 'h20,  0, NOP,          'h0);
        vecs[15] = mk(0, 'h0,   1, 32'hA0000020, 1,     1, 'h20,  0, NOP,          'h0);
        vecs[16] = mk(0, 'h0,   1, 32'hA0000021, 1,     1, 'h21,  1, 32'hA0000020, 'h20);
        vecs[17] = mk(0, 'h0,   0, 32'h0,        1,     1, 'h22,  1, 32'hA0000021, 'h21);
        vecs[18] = mk(0, 'h0,   0, 32'h0,        0,     1, 'h22,  0, NOP,          'h0);

        drive(0, '0, 0, 32'h0, 0);

        // Reset state while grst is held.
        @(negedge gclk);
        chk_reset_outputs("reset");
        @(posedge gclk); #1;
        grst = 1'b0;

`ifndef AEMB_IFETCH_BYPASS_EN
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].bra, vecs[i].tgt, vecs[i].ack, vecs[i].dat, vecs[i].gena);
            @(negedge gclk);
            chk($sformatf("v%0d_stb", i), 32'(stb0),  32'(vecs[i].e_stb));
            chk($sformatf("v%0d_adr", i), 32'(adr0),  32'(vecs[i].e_adr));
            chk($sformatf("v%0d_vld", i), 32'(qvld0), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_dat", i), qdat0,      vecs[i].e_dat);
            chk($sformatf("v%0d_pc", i),  32'(qpc0),  32'(vecs[i].e_pc));
            // Address wrap on the second instance, released in the same cycle.
            if (i == 1) chk("wrap_adr_c1", 32'(adr1), 32'h3FFFFFFF);
            if (i == 2) begin
                chk("wrap_adr_c2", 32'(adr1), 32'h0);
                chk("wrap_pc_c2",  32'(qpc1), 32'h3FFFFFFF);
            end
            if (i == 3) begin
                chk("wrap_adr_c3", 32'(adr1), 32'h1);
                chk("wrap_pc_c3",  32'(qpc1), 32'h0);
            end
            @(posedge gclk); #1;
        end
`endif

        // Queue three words with the strobe high, then reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 1, 32'hB0000000 + k, 0);
            @(posedge gclk); #1;
        end
        drive(0, '0, 0, 32'h0, 0);
        #1;
`ifndef AEMB_IFETCH_BYPASS_EN
        chk("pre_rst_stb", 32'(stb0),  32'd1);
        chk("pre_rst_vld", 32'(qvld0), 32'd1);
        chk("pre_rst_dat", qdat0,      32'hB0000000);
        chk("pre_rst_pc",  32'(qpc0),  32'h22);
`endif
        #2 grst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge gclk); #1;
        grst = 1'b0;
        @(posedge gclk); #1;

        // Ack on an empty queue with the consumer ready.
        drive(0, '0, 1, 32'h12345678, 1);
        #1;
        chk("lat_stb", 32'(stb0), 32'd1);
`ifdef AEMB_IFETCH_BYPASS_EN
        chk("byp_vld", 32'(qvld0), 32'd1);
        chk("byp_dat", qdat0,      32'h12345678);
        chk("byp_pc",  32'(qpc0),  32'h0);
`else
        chk("lat_vld_pre", 32'(qvld0), 32'd0);
        chk("lat_dat_pre", qdat0,      NOP);
`endif
        @(posedge gclk); #1;
        drive(0, '0, 0, 32'h0, 0);
        #1;
        chk("lat_adr_post", 32'(adr0), 32'h1);
        chk("lat_stb_post", 32'(stb0), 32'd1);
`ifdef AEMB_IFETCH_BYPASS_EN
        chk("byp_vld_post", 32'(qvld0), 32'd0);
        chk("byp_dat_post", qdat0,      NOP);
`else
        chk("lat_vld_post", 32'(qvld0), 32'd1);
        chk("lat_dat_post", qdat0,      32'h12345678);
        chk("lat_pc_post",  32'(qpc0),  32'h0);
        chk("no_strobe_0x10", 32'(saw_10), 32'd0);
`endif

        repeat (2) @(posedge gclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
